// File: rtl/vga_display_ctrl.sv
// VGA timing master and sprite compositor: raster counters, two-stage pixel pipeline,
// background/player/enemy compositing, per-frame tick and sticky player/enemy collision flag.
module vga_display_ctrl #(
   parameter int unsigned H_ACTIVE = 640,
   parameter int unsigned H_FP     = 16,
   parameter int unsigned H_SYNC   = 96,
   parameter int unsigned H_BP     = 48,
   parameter int unsigned V_ACTIVE = 480,
   parameter int unsigned V_FP     = 10,
   parameter int unsigned V_SYNC   = 2,
   parameter int unsigned V_BP     = 33,
   parameter int unsigned SPR_W    = 80,
   parameter int unsigned SPR_H    = 121,
   parameter logic [2:0]  BG_COLOR = 3'b010
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [9:0] player_pos_x,
   input  logic [9:0] player_pos_y,
   input  logic [2:0] player_data,
   input  logic [9:0] enemy_pos_x,
   input  logic [9:0] enemy_pos_y,
   input  logic [2:0] enemy_data,
   output logic [9:0] hcount,
   output logic [9:0] vcount,
   output logic       hsync,
   output logic       vsync,
   output logic [2:0] rgb,
   output logic       frame_tick,
   output logic       collision
);

   localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

   localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
   localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
   localparam logic [9:0] H_ACT    = 10'(H_ACTIVE);
   localparam logic [9:0] V_ACT    = 10'(V_ACTIVE);
   localparam logic [9:0] HS_START = 10'(H_ACTIVE + H_FP);
   localparam logic [9:0] HS_END   = 10'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [9:0] VS_START = 10'(V_ACTIVE + V_FP);
   localparam logic [9:0] VS_END   = 10'(V_ACTIVE + V_FP + V_SYNC);

   logic [9:0]  h1, v1;
   logic        s1_valid;
   logic        hit_pending;
   logic [10:0] p_xe, p_ye, e_xe, e_ye;
   logic        p_in, e_in, active, hit;
   logic        hs_raw, vs_raw;
   logic [2:0]  pix;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         hcount <= '0;
         vcount <= '0;
      end else if (hcount == H_LAST) begin
         hcount <= '0;
         vcount <= (vcount == V_LAST) ? '0 : vcount + 10'd1;
      end else begin
         hcount <= hcount + 10'd1;
      end
   end

   assign frame_tick = (hcount == '0) && (vcount == V_ACT);

   // Stage 1 lines the counts up with the sprite blocks' registered pixel data
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         h1       <= '0;
         v1       <= '0;
         s1_valid <= 1'b0;
      end else begin
         h1       <= hcount;
         v1       <= vcount;
         s1_valid <= 1'b1;
      end
   end

   always_comb begin
      p_xe   = {1'b0, player_pos_x} + 11'(SPR_W);
      p_ye   = {1'b0, player_pos_y} + 11'(SPR_H);
      e_xe   = {1'b0, enemy_pos_x} + 11'(SPR_W);
      e_ye   = {1'b0, enemy_pos_y} + 11'(SPR_H);
      p_in   = (h1 >= player_pos_x) && ({1'b0, h1} < p_xe) &&
               (v1 >= player_pos_y) && ({1'b0, v1} < p_ye);
      e_in   = (h1 >= enemy_pos_x) && ({1'b0, h1} < e_xe) &&
               (v1 >= enemy_pos_y) && ({1'b0, v1} < e_ye);
      active = (h1 < H_ACT) && (v1 < V_ACT);
      hs_raw = !((h1 >= HS_START) && (h1 < HS_END));
      vs_raw = !((v1 >= VS_START) && (v1 < VS_END));
      hit    = s1_valid && active && p_in && e_in &&
               (player_data != '0) && (enemy_data != '0);
      pix    = BG_COLOR;
      if (!active)
         pix = '0;
      else if (p_in && (player_data != '0))
         pix = player_data;
      else if (e_in && (enemy_data != '0))
         pix = enemy_data;
   end

   // Invalid stage-1 contents after reset are blanked rather than composited
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rgb   <= '0;
         hsync <= 1'b1;
         vsync <= 1'b1;
      end else begin
         rgb   <= s1_valid ? pix : '0;
         hsync <= s1_valid ? hs_raw : 1'b1;
         vsync <= s1_valid ? vs_raw : 1'b1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         hit_pending <= 1'b0;
         collision   <= 1'b0;
      end else if (frame_tick) begin
         collision   <= collision | hit_pending;
         hit_pending <= hit;
      end else if (hit) begin
         hit_pending <= 1'b1;
      end
   end

endmodule

// File: tb/tb_vga_display_ctrl.sv
// Directed bench for vga_display_ctrl on a reduced raster (200x50 clocks per frame)
// with small behavioural sprite blocks returning registered pixel data.
module tb_vga_display_ctrl;

   localparam int HA = 160, HF = 8, HS = 16, HB = 16;
   localparam int VA = 40, VF = 3, VS = 2, VB = 5;
   localparam int SW = 20, SH = 12;
   localparam int HT = HA + HF + HS + HB;
   localparam int VT = VA + VF + VS + VB;
   localparam int FT = HT * VT;

   logic       clk = 1'b0;
   logic       reset;
   logic [9:0] player_pos_x, player_pos_y, enemy_pos_x, enemy_pos_y;
   logic [2:0] player_data, enemy_data;
   logic [9:0] hcount, vcount;
   logic       hsync, vsync, frame_tick, collision;
   logic [2:0] rgb;

   int checks = 0;
   int errors = 0;
   int cyc = 0;

   // sprite behaviour controls
   logic p_en = 1'b0, e_en = 1'b0, p_hole = 1'b0, e_excl = 1'b0;

   always #5 clk = ~clk;

   vga_display_ctrl #(
      .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
      .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
      .SPR_W(SW), .SPR_H(SH), .BG_COLOR(3'b010)
   ) dut (
      .clk(clk), .reset(reset),
      .player_pos_x(player_pos_x), .player_pos_y(player_pos_y), .player_data(player_data),
      .enemy_pos_x(enemy_pos_x), .enemy_pos_y(enemy_pos_y), .enemy_data(enemy_data),
      .hcount(hcount), .vcount(vcount), .hsync(hsync), .vsync(vsync),
      .rgb(rgb), .frame_tick(frame_tick), .collision(collision)
   );

   function automatic logic in_win(input logic [9:0] h, input logic [9:0] v,
                                   input logic [9:0] px, input logic [9:0] py);
      return (int'(h) >= int'(px)) && (int'(h) < int'(px) + SW) &&
             (int'(v) >= int'(py)) && (int'(v) < int'(py) + SH);
   endfunction

   // Sprite blocks: pixel data registered one clock after sampling hcount/vcount
   always @(posedge clk) begin
      logic ip, ie;
      ip = in_win(hcount, vcount, player_pos_x, player_pos_y);
      ie = in_win(hcount, vcount, enemy_pos_x, enemy_pos_y);
      if (reset) begin
         player_data <= 3'b000;
         enemy_data  <= 3'b000;
      end else begin
         player_data <= (p_en && ip && !(p_hole && ie)) ? 3'b100 : 3'b000;
         enemy_data  <= (e_en && ie && (!e_excl || !ip || (hcount == 10'd115 && vcount == 10'd18)))
                        ? 3'b001 : 3'b000;
      end
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (cyc %0d)", tag, got, exp, cyc);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic run_until(input int t);
      for (int i = 0; i < 100000 && cyc < t; i++) step();
   endtask

   // Advance until rgb carries pixel (h,v), then compare it
   task automatic pix_check(input string tag, input int h, input int v, input logic [2:0] exp);
      int target;
      logic found;
      target = v * HT + h;
      found = 1'b0;
      for (int i = 0; i <= FT + 2; i++) begin
         if (((cyc - 2) % FT) == target) begin
            found = 1'b1;
            break;
         end
         step();
      end
      if (found) check(tag, 32'(rgb), 32'(exp));
      else check({tag, "_timeout"}, 0, 1);
   endtask

   initial begin
      int hl, vl, bgc, zc, oc, ticks, tick_at, first_hl;
      reset = 1'b1;
      player_pos_x = '0; player_pos_y = '0;
      enemy_pos_x  = '0; enemy_pos_y  = '0;
      #2;
      check("rst_hcount", 32'(hcount), 0);
      check("rst_vcount", 32'(vcount), 0);
      check("rst_hsync", 32'(hsync), 1);
      check("rst_vsync", 32'(vsync), 1);
      check("rst_rgb", 32'(rgb), 0);
      check("rst_tick", 32'(frame_tick), 0);
      check("rst_coll", 32'(collision), 0);
      repeat (3) @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      cyc = 0;

      // Frame 1: free run, background only
      hl = 0; vl = 0; bgc = 0; zc = 0; oc = 0; ticks = 0; tick_at = -1; first_hl = -1;
      for (int k = 0; k < FT; k++) begin
         step();
         if (hsync === 1'b0) begin
            hl++;
            if (first_hl < 0) first_hl = cyc;
         end
         if (vsync === 1'b0) vl++;
         if (rgb === 3'b010) bgc++;
         else if (rgb === 3'b000) zc++;
         else oc++;
         if (frame_tick === 1'b1) begin
            ticks++;
            tick_at = cyc;
         end
         if (cyc == 8001) begin
            player_pos_x = 10'd100; player_pos_y = 10'd10;
            enemy_pos_x  = 10'd110; enemy_pos_y  = 10'd15;
            p_en = 1'b1; e_en = 1'b1; p_hole = 1'b1; e_excl = 1'b0;
         end
      end
      check("first_hsync_low", 32'(first_hl), 32'(HA + HF + 2));
      check("hsync_low_clks", 32'(hl), 32'(HS * VT));
      check("vsync_low_clks", 32'(vl), 32'(VS * HT));
      check("bg_pixels", 32'(bgc), 32'(HA * VA));
      check("blank_pixels", 32'(zc), 32'(FT - HA * VA));
      check("other_pixels", 32'(oc), 0);
      check("tick_count", 32'(ticks), 1);
      check("tick_at", 32'(tick_at), 32'(VA * HT));
      check("wrap_hcount", 32'(hcount), 0);
      check("wrap_vcount", 32'(vcount), 0);

      // Frame 2: player transparent over the enemy window
      pix_check("f2_bg", 50, 5, 3'b010);
      pix_check("f2_above_player", 100, 9, 3'b010);
      pix_check("f2_player_corner", 100, 10, 3'b100);
      pix_check("f2_player_right", 119, 12, 3'b100);
      pix_check("f2_past_player", 120, 12, 3'b010);
      pix_check("f2_transparent", 115, 18, 3'b001);
      pix_check("f2_enemy", 125, 18, 3'b001);
      run_until(18000);
      check("f2_tick", 32'(frame_tick), 1);
      step();
      check("f2_no_coll", 32'(collision), 0);
      p_hole = 1'b0; e_excl = 1'b1;

      // Frame 3: single overlapping opaque pixel at (115,18)
      pix_check("f3_bg", 50, 5, 3'b010);
      pix_check("f3_priority", 115, 18, 3'b100);
      pix_check("f3_player", 116, 18, 3'b100);
      pix_check("f3_enemy", 125, 18, 3'b001);
      check("f3_coll_early", 32'(collision), 0);
      run_until(28000);
      check("f3_tick", 32'(frame_tick), 1);
      check("f3_coll_at_tick", 32'(collision), 0);
      step();
      check("f3_coll_set", 32'(collision), 1);
      enemy_pos_x = 10'd150; enemy_pos_y = 10'd30; e_excl = 1'b0;

      // Frame 4: enemy window clipped at the right and bottom edges
      pix_check("f4_player", 100, 10, 3'b100);
      pix_check("f4_enemy_last_col", 159, 35, 3'b001);
      pix_check("f4_clip_h", 160, 35, 3'b000);
      pix_check("f4_enemy_last_line", 155, 39, 3'b001);
      pix_check("f4_clip_v", 155, 40, 3'b000);
      run_until(38001);
      check("f4_coll_sticky", 32'(collision), 1);
      run_until(48001);
      check("f5_coll_sticky", 32'(collision), 1);
      run_until(58001);
      check("f6_coll_sticky", 32'(collision), 1);

      // Reset mid-frame at (100,20)
      run_until(64100);
      check("pre_rst_hcount", 32'(hcount), 100);
      check("pre_rst_vcount", 32'(vcount), 20);
      #2 reset = 1'b1;
      #1;
      check("mid_rst_hcount", 32'(hcount), 0);
      check("mid_rst_vcount", 32'(vcount), 0);
      check("mid_rst_hsync", 32'(hsync), 1);
      check("mid_rst_vsync", 32'(vsync), 1);
      check("mid_rst_rgb", 32'(rgb), 0);
      check("mid_rst_tick", 32'(frame_tick), 0);
      check("mid_rst_coll", 32'(collision), 0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      cyc = 0;
      step();
      check("rel_hcount", 32'(hcount), 1);
      check("rel_rgb1", 32'(rgb), 0);
      step();
      check("rel_rgb2", 32'(rgb), 32'(3'b010));
      ticks = 0; tick_at = -1;
      for (int k = 0; k < VA * HT - 2; k++) begin
         step();
         if (frame_tick === 1'b1) begin
            ticks++;
            tick_at = cyc;
         end
      end
      check("rel_tick_count", 32'(ticks), 1);
      check("rel_tick_at", 32'(tick_at), 32'(VA * HT));

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
